// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory: FSM state encoding,
// address-width helper and the even-parity function used by DMEM_PARITY_EN.
package dmem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } dmem_state_e;

    // Parity helper takes a fixed-width operand; callers zero-extend.
    localparam int PAR_MAX_W = 64;

    function automatic int dmem_aw(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// Write/read request bus between the store stage (master) and the data memory
// (slave). Optional parity hook is only meaningful with DMEM_PARITY_EN.
interface data_memory_if
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int DATA_MEMORY_SIZE = 64
);
    localparam int AW = dmem_aw(DATA_MEMORY_SIZE);

    // Handshake: wr_en and rd_en are single-cycle request strobes with no
    // back-pressure; each high cycle is one request, accepted only once
    // init_done is high. rd_valid pulses for exactly one cycle per accepted
    // read, one cycle after the request, and qualifies rd_data and parity_err.
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic                  err_inject;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  init_done;
    logic                  parity_err;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, err_inject,
        input  rd_data, rd_valid, init_done, parity_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, err_inject,
        output rd_data, rd_valid, init_done, parity_err
    );

endinterface

// File: rtl/dmem_parity.sv
// Combinational even-parity generate (write side, with inversion hook) and
// check (read side) for one memory word of W data bits plus a parity bit.
module dmem_parity
    import dmem_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] wr_data_i,
    input  logic         err_inject_i,
    output logic         wr_par_o,
    input  logic [W:0]   rd_word_i,
    output logic         rd_err_o
);

    assign wr_par_o = even_parity(PAR_MAX_W'(wr_data_i)) ^ err_inject_i;
    assign rd_err_o = even_parity(PAR_MAX_W'(rd_word_i[W-1:0])) ^ rd_word_i[W];

endmodule

// File: rtl/data_memory.sv
// Synchronous data memory with post-reset sequential clear, 1-cycle read latency
// and write-first forwarding. Define DMEM_PARITY_EN to store/check even parity.
module data_memory
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int DATA_MEMORY_SIZE = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    data_memory_if.slave bus,
    output dmem_state_e  state_o
);

    localparam int AW = dmem_aw(DATA_MEMORY_SIZE);
`ifdef DMEM_PARITY_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif
    localparam logic [AW-1:0] LAST_ADDR = AW'(DATA_MEMORY_SIZE - 1);
    localparam logic [AW:0]   SIZE_EXT  = (AW + 1)'(DATA_MEMORY_SIZE);

    dmem_state_e           state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [MW-1:0]         mem_q [DATA_MEMORY_SIZE];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  perr_q, perr_d;

    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [MW-1:0]         mem_wdata;
    logic [MW-1:0]         wr_word;
    logic [MW-1:0]         rd_word;
    logic                  rd_par_err;
    logic                  wr_in_range, rd_in_range, fwd;

    assign wr_in_range = ({1'b0, bus.wr_addr} < SIZE_EXT);
    assign rd_in_range = ({1'b0, bus.rd_addr} < SIZE_EXT);
    assign fwd         = bus.wr_en && wr_in_range && (bus.wr_addr == bus.rd_addr);
    // Write-first: a same-address write this cycle bypasses the array.
    assign rd_word     = fwd ? wr_word : mem_q[bus.rd_addr];

`ifdef DMEM_PARITY_EN
    logic wr_par;

    dmem_parity #(.W(DATA_WIDTH)) u_parity (
        .wr_data_i    (bus.wr_data),
        .err_inject_i (bus.err_inject),
        .wr_par_o     (wr_par),
        .rd_word_i    (rd_word),
        .rd_err_o     (rd_par_err)
    );

    assign wr_word = {wr_par, bus.wr_data};
`else
    logic unused_err_inject;

    assign unused_err_inject = bus.err_inject;
    assign wr_word           = bus.wr_data;
    assign rd_par_err        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_we     = 1'b0;
        mem_waddr  = bus.wr_addr;
        mem_wdata  = wr_word;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        perr_d     = 1'b0;
        case (state_q)
            INIT: begin
                // All-zero word already carries correct even parity.
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                cnt_d     = cnt_q + AW'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                mem_we = bus.wr_en && wr_in_range;
                if (bus.rd_en) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = rd_in_range ? rd_word[DATA_WIDTH-1:0] : '0;
                    perr_d     = rd_in_range && rd_par_err;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            perr_q     <= perr_d;
        end
    end

    // Array has no reset; the INIT sweep provides defined contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.parity_err = perr_q;
    assign bus.init_done  = (state_q == IDLE);
    assign state_o        = state_q;

endmodule
